// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 bit mux: steps sel, samples mux_o per channel, emits an 8-bit word over valid/ready.
// Optional MUX_SCAN_PARITY_EN adds out_parity (XOR of out_data), registered alongside out_data.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_o,
  output logic [2:0] sel,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic [7:0] out_data,
  output logic       out_parity
`else
  output logic [7:0] out_data
`endif
);

  if (SETTLE_CYC == 0 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE_CYC must be in 1..15");
  end

  localparam logic [2:0] FIRST_CH = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST_CH  = MSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] data_q, data_d;
  logic       parity_q, parity_d;
  logic       start_scan;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    data_d     = data_q;
    start_scan = 1'b0;

    if (abort) begin
      state_d = IDLE;
      sel_d   = FIRST_CH;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: start_scan = start;
        SCAN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d           = 4'd0;
            shadow_d[sel_q] = mux_o;
            if (sel_q == LAST_CH) begin
              data_d  = shadow_d;
              state_d = HOLD;
              sel_d   = FIRST_CH;
            end else begin
              sel_d = MSB_FIRST ? 3'(sel_q - 3'd1) : 3'(sel_q + 3'd1);
            end
          end else begin
            cnt_d = 4'(cnt_q + 4'd1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (start) start_scan = 1'b1;
            else       state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // Entry into SCAN is identical whether coming from IDLE or a completed handshake.
      if (start_scan) begin
        state_d  = SCAN;
        sel_d    = FIRST_CH;
        cnt_d    = 4'd0;
        shadow_d = 8'd0;
      end
    end

    parity_d = ^data_d;
  end

  // NOTE: the shadow word is a plain register, so it is reset with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= FIRST_CH;
      cnt_q    <= 4'd0;
      shadow_q <= 8'd0;
      data_q   <= 8'd0;
      parity_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      parity_q <= parity_d;
    end
  end

  assign sel       = sel_q;
  assign busy      = (state_q == SCAN);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;

`ifdef MUX_SCAN_PARITY_EN
  assign out_parity = parity_q;
`else
  logic unused_parity;
  assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: three instances (SETTLE_CYC=1, SETTLE_CYC=3, MSB_FIRST=1).
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int checks = 0;
  int errors = 0;

  // Instance A: SETTLE_CYC=1, LSB first
  logic a_start, a_abort, a_ready, a_busy, a_valid, a_mux, a_par;
  logic [2:0] a_sel;
  logic [7:0] a_data, a_pat;
  // Instance B: SETTLE_CYC=3, glitch injection
  logic b_start, b_abort, b_ready, b_busy, b_valid, b_mux, b_par, b_glitch;
  logic [2:0] b_sel;
  logic [7:0] b_data, b_pat;
  // Instance C: MSB_FIRST=1
  logic c_start, c_abort, c_ready, c_busy, c_valid, c_mux, c_par;
  logic [2:0] c_sel;
  logic [7:0] c_data, c_pat;

  assign a_mux = a_pat[a_sel];
  assign b_mux = b_pat[b_sel] ^ b_glitch;
  assign c_mux = c_pat[c_sel];

  mux_scan_ctrl #(.SETTLE_CYC(1), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .mux_o(a_mux),
    .sel(a_sel), .busy(a_busy), .out_valid(a_valid), .out_ready(a_ready),
`ifdef MUX_SCAN_PARITY_EN
    .out_parity(a_par),
`endif
    .out_data(a_data));

  mux_scan_ctrl #(.SETTLE_CYC(3), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .mux_o(b_mux),
    .sel(b_sel), .busy(b_busy), .out_valid(b_valid), .out_ready(b_ready),
`ifdef MUX_SCAN_PARITY_EN
    .out_parity(b_par),
`endif
    .out_data(b_data));

  mux_scan_ctrl #(.SETTLE_CYC(1), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort), .mux_o(c_mux),
    .sel(c_sel), .busy(c_busy), .out_valid(c_valid), .out_ready(c_ready),
`ifdef MUX_SCAN_PARITY_EN
    .out_parity(c_par),
`endif
    .out_data(c_data));

`ifndef MUX_SCAN_PARITY_EN
  assign a_par = 1'b0;
  assign b_par = 1'b0;
  assign c_par = 1'b0;
`endif

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: expected words pushed at start, popped when a handshake is about to complete.
  logic [7:0] qa[$], qb[$], qc[$];

  always @(negedge clk) begin
    if (rst_n && a_valid && a_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_word: unexpected word 0x%0h, none required", a_data);
      end else begin
        logic [7:0] e;
        e = qa.pop_front();
        check("a_word", a_data, e);
`ifdef MUX_SCAN_PARITY_EN
        check("a_parity", {7'd0, a_par}, {7'd0, ^e});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_valid && b_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_word: unexpected word 0x%0h, none required", b_data);
      end else begin
        check("b_word", b_data, qb.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && c_valid && c_ready) begin
      if (qc.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_word: unexpected word 0x%0h, none required", c_data);
      end else begin
        check("c_word", c_data, qc.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {a_start, a_abort, a_ready} = '0;
    {b_start, b_abort, b_ready, b_glitch} = '0;
    {c_start, c_abort, c_ready} = '0;
    a_pat = 8'h00; b_pat = 8'h00; c_pat = 8'h00;
    #12 rst_n = 1'b1;

    // Reset state
    check("rst_a_sel",   {5'd0, a_sel}, 8'd0);
    check("rst_a_busy",  {7'd0, a_busy}, 8'd0);
    check("rst_a_valid", {7'd0, a_valid}, 8'd0);
    check("rst_a_data",  a_data, 8'h00);
    check("rst_c_sel",   {5'd0, c_sel}, 8'd7);

    // Basic scan, SETTLE_CYC=1
    tick();
    a_pat = 8'h63;
    qa.push_back(8'h63);
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("a_sel_step", {5'd0, a_sel}, 8'(k));
      check("a_busy_scan", {7'd0, a_busy}, 8'd1);
      check("a_valid_early", {7'd0, a_valid}, 8'd0);
      tick();
    end
    check("a_valid_lat8", {7'd0, a_valid}, 8'd1);
    check("a_data_63", a_data, 8'h63);
    check("a_busy_hold", {7'd0, a_busy}, 8'd0);
    check("a_sel_return", {5'd0, a_sel}, 8'd0);
`ifdef MUX_SCAN_PARITY_EN
    check("a_par_63", {7'd0, a_par}, 8'd0);
`endif

    // Backpressure: start during stall is ignored
    for (int i = 0; i < 5; i++) begin
      a_start = (i == 2);
      check("a_stall_valid", {7'd0, a_valid}, 8'd1);
      check("a_stall_data", a_data, 8'h63);
      tick();
    end
    a_start = 1'b0;
    check("a_stall_busy", {7'd0, a_busy}, 8'd0);
    check("a_stall_valid_end", {7'd0, a_valid}, 8'd1);

    // Handshake plus start: back-to-back scan
    qa.push_back(8'h63);
    a_ready = 1'b1; a_start = 1'b1; tick(); a_start = 1'b0;
    check("b2b_busy", {7'd0, a_busy}, 8'd1);
    check("b2b_valid", {7'd0, a_valid}, 8'd0);
    check("b2b_sel", {5'd0, a_sel}, 8'd0);
    for (int i = 0; i < 8; i++) tick();
    check("b2b_valid_done", {7'd0, a_valid}, 8'd1);
    check("b2b_data", a_data, 8'h63);
    tick();
    check("b2b_idle_valid", {7'd0, a_valid}, 8'd0);
    check("b2b_idle_busy", {7'd0, a_busy}, 8'd0);

    // Abort at 4th channel of an 8'hFF scan
    a_pat = 8'hFF;
    a_start = 1'b1; tick(); a_start = 1'b0;
    tick(); tick(); tick();
    check("abort_sel_pre", {5'd0, a_sel}, 8'd3);
    a_abort = 1'b1; tick(); a_abort = 1'b0;
    check("abort_busy", {7'd0, a_busy}, 8'd0);
    check("abort_valid", {7'd0, a_valid}, 8'd0);
    check("abort_sel", {5'd0, a_sel}, 8'd0);
    check("abort_data", a_data, 8'h63);
    for (int i = 0; i < 10; i++) tick();
    check("abort_no_word", {7'd0, a_valid}, 8'd0);

    // Simultaneous abort and start in IDLE: stays IDLE
    a_abort = 1'b1; a_start = 1'b1; tick();
    a_abort = 1'b0; a_start = 1'b0;
    check("abort_start_busy", {7'd0, a_busy}, 8'd0);

    // Async reset mid-scan
    a_pat = 8'h5A;
    a_start = 1'b1; tick(); a_start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel", {5'd0, a_sel}, 8'd0);
    check("arst_busy", {7'd0, a_busy}, 8'd0);
    check("arst_valid", {7'd0, a_valid}, 8'd0);
    check("arst_data", a_data, 8'h00);
    #1 rst_n = 1'b1;
    tick();
    a_pat = 8'h96;
    qa.push_back(8'h96);
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("post_rst_valid", {7'd0, a_valid}, 8'd1);
    check("post_rst_data", a_data, 8'h96);
    tick();

    // Dwell and glitch, SETTLE_CYC=3
    b_pat = 8'hA5;
    qb.push_back(8'hA5);
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int ch = 0; ch < 8; ch++) begin
      for (int d = 0; d < 3; d++) begin
        b_glitch = (d < 2);
        check("b_sel_dwell", {5'd0, b_sel}, 8'(ch));
        check("b_valid_early", {7'd0, b_valid}, 8'd0);
        tick();
      end
    end
    b_glitch = 1'b0;
    check("b_valid_lat24", {7'd0, b_valid}, 8'd1);
    check("b_data_a5", b_data, 8'hA5);
    b_ready = 1'b1; tick();
    check("b_valid_clear", {7'd0, b_valid}, 8'd0);

    // MSB_FIRST scan
    c_pat = 8'h3C;
    qc.push_back(8'h3C);
    c_start = 1'b1; tick(); c_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("c_sel_down", {5'd0, c_sel}, 8'(7 - k));
      tick();
    end
    check("c_valid", {7'd0, c_valid}, 8'd1);
    check("c_data_3c", c_data, 8'h3C);
    check("c_sel_return", {5'd0, c_sel}, 8'd7);
    c_ready = 1'b1; tick();
    tick();

    check("qa_drained", 8'(qa.size()), 8'd0);
    check("qb_drained", 8'(qb.size()), 8'd0);
    check("qc_drained", 8'(qc.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 8:1 bit mux.
- Drives the mux's 3-bit select through channels 0..7, samples the single-bit mux output once per channel, and assembles the samples into one 8-bit word.
- Presents the word downstream over a valid/ready handshake.
- Turns the combinational mux into a timed parallel-capture path.

Parameters:
- SETTLE_CYC, 1, cycles each select value is held before sampling; legal range 1..15.
- MSB_FIRST, 0, 0: sel scans 0→7; 1: sel scans 7→0. Word bit mapping is unchanged either way.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one scan; honoured only in IDLE, or in HOLD in the same cycle the handshake completes.
- abort  in  1  synchronous; returns to IDLE next edge and discards the partial word.
- mux_o  in  1  output of the downstream 8:1 mux.
- sel  out  3  select to the mux.
- busy  out  1  high in SCAN.
- out_valid  out  1  word available (HOLD).
- out_ready  in  1  consumer accepts the word.
- out_data  out  8  captured word; bit n = mux_o sampled while sel==n.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: sel=0 (7 if MSB_FIRST), busy=0, out_valid=0, out_data=0, state=IDLE, dwell counter=0.
- States:
  - IDLE: start=1 → SCAN. At that edge, sel=first channel, cnt=0, shadow word cleared.
  - SCAN: cnt counts 0..SETTLE_CYC-1 per channel.
    - At the edge where cnt==SETTLE_CYC-1: shadow[sel] <= mux_o, cnt <= 0, sel steps to the next channel.
    - After the last channel is sampled: out_data <= full word including that sample, out_valid <= 1, state → HOLD. sel returns to the first channel.
  - HOLD: out_data stable while out_valid=1.
    - out_valid && out_ready at an edge → out_valid <= 0.
    - Same cycle with start=1 → SCAN directly, with the same entry actions as from IDLE.
    - Same cycle with start=0 → IDLE.
- Latency:
  - out_valid rises at the edge 8*SETTLE_CYC cycles after the edge that accepted start.
  - SETTLE_CYC=1 gives 8 cycles.
- Sampling: mux_o is registered only on the last dwell cycle of each channel. Value changes on mux_o earlier in the dwell are ignored.
- sel changes only on a clock edge; it is registered and glitch-free.
- start in SCAN is ignored and not queued. start in HOLD without out_ready is ignored.
- out_ready outside HOLD has no effect.
- abort:
  - Has priority over all other inputs.
  - From SCAN or HOLD: state → IDLE, out_valid → 0, busy → 0, sel → first channel.
  - out_data keeps its last completed value.
  - abort in IDLE has no effect.
- Simultaneous abort and start: abort wins; the block stays in IDLE for that cycle.
- Reset mid-scan: all outputs return to their reset values immediately, without waiting for clk.
- Counter width is 4 bits. Synthesis must fail or assert if SETTLE_CYC is 0 or greater than 15.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- Defined:
  - Adds output out_parity (1 bit) = XOR of all 8 bits of out_data.
  - Registered at the same edge as out_data; reset value 0.
  - Held with out_data during HOLD and after abort.
- Undefined: the port does not exist; behaviour is otherwise identical.

Test Plan:
- Basic scan: mux model inputs=8'b01100011, SETTLE_CYC=1, start pulse → sel steps 0..7 on consecutive edges; out_valid high 8 cycles after start; out_data=8'h63; out_parity=0 if enabled.
- Dwell and glitch: SETTLE_CYC=3, inputs=8'hA5, mux_o forced wrong on the first two dwell cycles of each channel → out_data=8'hA5; out_valid 24 cycles after start.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in HOLD → out_data stays 8'h63, and a start pulse during the stall is ignored.
  - Then out_ready=1 together with start=1 → new scan begins next cycle, busy=1, out_valid=0.
- Abort: abort at the 4th channel of a scan of 8'hFF after a completed 8'h63 word → IDLE next edge; out_valid=0; out_data remains 8'h63; no word is emitted.
- Async reset mid-scan: drop rst_n between edges during SCAN → sel=0, busy=0, out_valid=0, out_data=0 before the next edge. A following start produces a correct word.
- MSB_FIRST=1, inputs=8'h3C → sel sequence 7,6,...,0; out_data=8'h3C.
